instr_sequencer: RTL

- Multi-cycle control FSM for the register/ALU datapath.
- Fetches each 10-bit instruction {op[3:0], rx[2:0], ry[2:0]} presented combinationally by the instruction memory at the current PC.
- Drives register-file, accumulator, ALU and bus-mux controls step by step.
- Returns done/branch/branchaddress to the memory's PC logic; branch has priority over done there.

---
 rtl/instr_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Multi-cycle control FSM for the register/ALU datapath. Latches the
//   instruction word shown by the instruction memory at the current PC and
//   steps the register-file, accumulator, ALU and bus-mux controls through
//   one to three execute cycles. It returns done/branch/branchaddress to
//   the PC logic and counts retired instructions.
//
//   State table
//     state   | meaning
//     --------+------------------------------------------------------------
//     S_FETCH | idle; latch instruction into IR when run = 1
//     S_E1    | first execute step (LOAD/MOVE/NOP/BR complete here)
//     S_E2    | ADD/XOR: G <= A op bus(ry)
//     S_E3    | ADD/XOR: Rx <= G, instruction complete
//
//   Ports
//     clk           in   system clock, rising edge
//     rst           in   synchronous active-high reset
//     run           in   fetch enable, only looked at in S_FETCH
//     instruction   in   {op, rx, ry} from instruction memory
//     rin           out  one-hot register write enables, bit n-1 -> Rn
//     a_in          out  load accumulator A from bus
//     g_in          out  load G from ALU
//     alu_op        out  0 = add, 1 = xor
//     bus_sel       out  0 = data-in, 1..6 = R1..R6, 7 = G
//     done          out  one-cycle pulse, PC advances by one
//     branch        out  one-cycle pulse, PC loads branchaddress
//     branchaddress out  branch target, 0 unless branch = 1
//     busy          out  1 whenever not in S_FETCH
//     retired       out  completed-instruction count, wraps

module instr_sequencer #(
  parameter int OP_SIZE   = 4,
  parameter int ARG_SIZE  = 3,
  parameter int ARG_NUM   = 2,
  parameter int PC_WIDTH  = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                run,
  input  logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0] instruction,
  output logic [5:0]                          rin,
  output logic                                a_in,
  output logic                                g_in,
  output logic                                alu_op,
  output logic [ARG_SIZE-1:0]                 bus_sel,
  output logic                                done,
  output logic                                branch,
  output logic [PC_WIDTH-1:0]                 branchaddress,
  output logic                                busy,
  output logic [CNT_WIDTH-1:0]                retired
);

  localparam int IW = OP_SIZE + ARG_NUM * ARG_SIZE;

  localparam logic [OP_SIZE-1:0] OP_LOAD = OP_SIZE'(4'b0000);
  localparam logic [OP_SIZE-1:0] OP_MOVE = OP_SIZE'(4'b0001);
  localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(4'b0010);
  localparam logic [OP_SIZE-1:0] OP_XOR  = OP_SIZE'(4'b0011);
  localparam logic [OP_SIZE-1:0] OP_BR   = OP_SIZE'(4'b1000);

  localparam logic [ARG_SIZE-1:0] SEL_DIN = ARG_SIZE'(0);
  localparam logic [ARG_SIZE-1:0] SEL_G   = ARG_SIZE'(7);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_E1    = 2'd1,
    S_E2    = 2'd2,
    S_E3    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ir_q, ir_d;
  logic [CNT_WIDTH-1:0] retired_q;

  logic [OP_SIZE-1:0]  op;
  logic [ARG_SIZE-1:0] rx;
  logic [ARG_SIZE-1:0] ry;

  assign op = ir_q[IW-1 -: OP_SIZE];
  assign rx = ir_q[2*ARG_SIZE-1 -: ARG_SIZE];
  assign ry = ir_q[ARG_SIZE-1:0];

  // Register fields 0 (no register) and 7 (PC) have no write enable.
  function automatic logic [5:0] dest(input logic [ARG_SIZE-1:0] r);
    logic [5:0] oh;
    oh = 6'b000000;
    case (r)
      ARG_SIZE'(1): oh = 6'b000001;
      ARG_SIZE'(2): oh = 6'b000010;
      ARG_SIZE'(3): oh = 6'b000100;
      ARG_SIZE'(4): oh = 6'b001000;
      ARG_SIZE'(5): oh = 6'b010000;
      ARG_SIZE'(6): oh = 6'b100000;
      default:      oh = 6'b000000;
    endcase
    return oh;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      if (done || branch) begin
        retired_q <= retired_q + CNT_WIDTH'(1);
      end
    end
  end

  // Outputs depend only on state and IR; the live instruction word only
  // feeds the IR capture.
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    rin           = 6'b000000;
    a_in          = 1'b0;
    g_in          = 1'b0;
    alu_op        = 1'b0;
    bus_sel       = SEL_DIN;
    done          = 1'b0;
    branch        = 1'b0;
    branchaddress = '0;
    busy          = 1'b1;

    case (state_q)
      S_FETCH: begin
        busy = 1'b0;
        if (run) begin
          ir_d    = instruction;
          state_d = S_E1;
        end
      end

      S_E1: begin
        state_d = S_FETCH;
        case (op)
          OP_LOAD: begin
            bus_sel = SEL_DIN;
            rin     = dest(rx);
            done    = 1'b1;
          end
          OP_MOVE: begin
            bus_sel = ry;
            rin     = dest(rx);
            done    = 1'b1;
          end
          OP_ADD, OP_XOR: begin
            bus_sel = rx;
            a_in    = 1'b1;
            state_d = S_E2;
          end
          OP_BR: begin
            branch        = 1'b1;
            branchaddress = ir_q[PC_WIDTH-1:0];
          end
          default: begin
            done = 1'b1;
          end
        endcase
      end

      S_E2: begin
        bus_sel = ry;
        g_in    = 1'b1;
        // ADD and XOR differ only in the opcode LSB.
        alu_op  = ir_q[IW-OP_SIZE];
        state_d = S_E3;
      end

      S_E3: begin
        bus_sel = SEL_G;
        rin     = dest(rx);
        done    = 1'b1;
        state_d = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign retired = retired_q;

endmodule
